// File: rtl/boid_state_mem.sv
// boid_state_mem
//
// Per-boid state memory for the flocking accelerator controller. Each of the six state fields
// lives in its own synchronous RAM, so the per-field write mask never needs a read-modify-write.
// Requests use a valid/ready handshake. Reads return data exactly 2 cycles after acceptance:
// the address is registered at acceptance, and the RAM is read into the output registers on
// the following edge.
//
// Configuration macro: BOID_MEM_INIT_EN
//   defined   - after every reset an INIT sequencer writes deterministic starting state to each
//               entry, one per cycle, before requests are accepted.
//   undefined - no INIT state; requests are accepted right after reset and RAM contents are
//               undefined until written.
//
// Ports
//   clk              sole clock, posedge
//   reset            asynchronous, active-high reset
//   req_valid        request present
//   req_ready        block accepts a request this cycle
//   req_we           1 = write, 0 = read
//   req_boid         target boid index (IDX_W bits, may exceed NUM_BOIDS-1)
//   w_en             bit 0 global enable; bits 1..6 select x, y, vx, vy, vx_acc, vy_acc
//   x_in..vy_acc_in  write data (28/27/21/21/32/32 bits)
//   resp_valid       one-cycle pulse marking valid read data
//   x_out..vy_acc_out read data, held between responses
module boid_state_mem #(
  parameter int NUM_BOIDS = 2,
  parameter int IDX_W     = $clog2(NUM_BOIDS) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [IDX_W-1:0] req_boid,
  input  logic [6:0]       w_en,
  input  logic [27:0]      x_in,
  input  logic [26:0]      y_in,
  input  logic [20:0]      vx_in,
  input  logic [20:0]      vy_in,
  input  logic [31:0]      vx_acc_in,
  input  logic [31:0]      vy_acc_in,
  output logic             resp_valid,
  output logic [27:0]      x_out,
  output logic [26:0]      y_out,
  output logic [20:0]      vx_out,
  output logic [20:0]      vy_out,
  output logic [31:0]      vx_acc_out,
  output logic [31:0]      vy_acc_out
);

  localparam int AW = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1;

  // ---------------------------------------------------------------------------------------------
  // Storage: one RAM per field
  // ---------------------------------------------------------------------------------------------
  logic [27:0] mem_x      [NUM_BOIDS];
  logic [26:0] mem_y      [NUM_BOIDS];
  logic [20:0] mem_vx     [NUM_BOIDS];
  logic [20:0] mem_vy     [NUM_BOIDS];
  logic [31:0] mem_vx_acc [NUM_BOIDS];
  logic [31:0] mem_vy_acc [NUM_BOIDS];

  // ---------------------------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------------------------
`ifdef BOID_MEM_INIT_EN
  typedef enum logic [0:0] {StInit, StServe} state_e;
  localparam state_e ResetState = StInit;
`else
  typedef enum logic [0:0] {StServe} state_e;
  localparam state_e ResetState = StServe;
`endif

  state_e state_q, state_d;
  logic   init_active;

`ifdef BOID_MEM_INIT_EN
  logic [AW-1:0] init_cnt_q;
  logic          init_last;

  assign init_last = (init_cnt_q == AW'(NUM_BOIDS - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ResetState;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
`ifdef BOID_MEM_INIT_EN
    unique case (state_q)
      StInit:  if (init_last) state_d = StServe;
      StServe: state_d = StServe;
      default: state_d = StInit;
    endcase
`endif
  end

  always_comb begin
    // Gated by reset so the handshake is closed while reset is held.
    req_ready = (state_q == StServe) && !reset;
`ifdef BOID_MEM_INIT_EN
    init_active = (state_q == StInit);
`else
    init_active = 1'b0;
`endif
  end

`ifdef BOID_MEM_INIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_cnt_q <= '0;
    end else if (init_active) begin
      init_cnt_q <= init_last ? '0 : init_cnt_q + 1'b1;
    end
  end
`endif

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------
  logic          req_accept;
  logic          req_in_range;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] wr_addr;
  logic [5:0]    wr_fld;
  logic [27:0]   wd_x;
  logic [26:0]   wd_y;
  logic [20:0]   wd_vx;
  logic [20:0]   wd_vy;
  logic [31:0]   wd_vx_acc;
  logic [31:0]   wd_vy_acc;

  assign req_accept   = req_valid && req_ready;
  assign req_in_range = (int'(req_boid) < NUM_BOIDS);
  assign req_addr     = req_boid[AW-1:0];

  always_comb begin
    wr_addr   = req_addr;
    wr_fld    = '0;
    wd_x      = x_in;
    wd_y      = y_in;
    wd_vx     = vx_in;
    wd_vy     = vy_in;
    wd_vx_acc = vx_acc_in;
    wd_vy_acc = vy_acc_in;
    if (req_accept && req_we && req_in_range && w_en[0]) begin
      wr_fld = w_en[6:1];
    end
`ifdef BOID_MEM_INIT_EN
    // INIT never overlaps a request: req_ready is low throughout.
    if (init_active) begin
      wr_addr   = init_cnt_q;
      wr_fld    = '1;
      wd_x      = 28'((32'd120 + 32'd40 * 32'(init_cnt_q)) << 16);
      wd_y      = 27'((32'd120 + 32'd40 * 32'(init_cnt_q)) << 16);
      wd_vx     = 21'h50000;
      wd_vy     = 21'h40000;
      wd_vx_acc = '0;
      wd_vy_acc = '0;
    end
`endif
  end

  // RAM write ports carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fld[0]) mem_x[wr_addr]      <= wd_x;
    if (wr_fld[1]) mem_y[wr_addr]      <= wd_y;
    if (wr_fld[2]) mem_vx[wr_addr]     <= wd_vx;
    if (wr_fld[3]) mem_vy[wr_addr]     <= wd_vy;
    if (wr_fld[4]) mem_vx_acc[wr_addr] <= wd_vx_acc;
    if (wr_fld[5]) mem_vy_acc[wr_addr] <= wd_vy_acc;
  end

  // ---------------------------------------------------------------------------------------------
  // Read pipeline: stage 1 registers the address, stage 2 reads the RAM into the outputs
  // ---------------------------------------------------------------------------------------------
  logic          rd_valid_q;
  logic          rd_oor_q;
  logic [AW-1:0] rd_addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      rd_valid_q <= req_accept && !req_we;
      if (req_accept && !req_we) begin
        rd_addr_q <= req_addr;
        rd_oor_q  <= !req_in_range;
      end
    end
  end

  // A write accepted in the cycle after a read lands on the same edge that samples the RAM,
  // so the read returns the old contents.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      x_out      <= '0;
      y_out      <= '0;
      vx_out     <= '0;
      vy_out     <= '0;
      vx_acc_out <= '0;
      vy_acc_out <= '0;
    end else begin
      resp_valid <= rd_valid_q;
      if (rd_valid_q) begin
        if (rd_oor_q) begin
          x_out      <= '0;
          y_out      <= '0;
          vx_out     <= '0;
          vy_out     <= '0;
          vx_acc_out <= '0;
          vy_acc_out <= '0;
        end else begin
          x_out      <= mem_x[rd_addr_q];
          y_out      <= mem_y[rd_addr_q];
          vx_out     <= mem_vx[rd_addr_q];
          vy_out     <= mem_vy[rd_addr_q];
          vx_acc_out <= mem_vx_acc[rd_addr_q];
          vy_acc_out <= mem_vy_acc[rd_addr_q];
        end
      end
    end
  end

endmodule

// File: tb/tb_boid_state_mem.sv
// Testbench for boid_state_mem (NUM_BOIDS = 2). Stimulus updates an array-based reference
// model and queues the expected read responses; a separate monitor pops and compares them.
module tb_boid_state_mem;

  localparam int NB = 2;
  localparam int IW = 2;
`ifdef BOID_MEM_INIT_EN
  localparam int ExpRdy = 2;
`else
  localparam int ExpRdy = 0;
`endif

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [IW-1:0] req_boid;
  logic [6:0]    w_en;
  logic [27:0]   x_in;
  logic [26:0]   y_in;
  logic [20:0]   vx_in, vy_in;
  logic [31:0]   vx_acc_in, vy_acc_in;
  logic          resp_valid;
  logic [27:0]   x_out;
  logic [26:0]   y_out;
  logic [20:0]   vx_out, vy_out;
  logic [31:0]   vx_acc_out, vy_acc_out;

  boid_state_mem #(.NUM_BOIDS(NB), .IDX_W(IW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_boid   (req_boid),
    .w_en       (w_en),
    .x_in       (x_in),
    .y_in       (y_in),
    .vx_in      (vx_in),
    .vy_in      (vy_in),
    .vx_acc_in  (vx_acc_in),
    .vy_acc_in  (vy_acc_in),
    .resp_valid (resp_valid),
    .x_out      (x_out),
    .y_out      (y_out),
    .vx_out     (vx_out),
    .vy_out     (vy_out),
    .vx_acc_out (vx_acc_out),
    .vy_acc_out (vy_acc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int watch_cyc = -1;

  // Reference model
  logic [27:0] m_x   [NB];
  logic [26:0] m_y   [NB];
  logic [20:0] m_vx  [NB];
  logic [20:0] m_vy  [NB];
  logic [31:0] m_vxa [NB];
  logic [31:0] m_vya [NB];

  typedef struct {
    logic [27:0] x;
    logic [26:0] y;
    logic [20:0] vx;
    logic [20:0] vy;
    logic [31:0] vxa;
    logic [31:0] vya;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end
  endfunction

  function automatic logic [27:0] init_x(input int i);
    return 28'((120 + 40 * i) << 16);
  endfunction

  function automatic logic [26:0] init_y(input int i);
    return 27'((120 + 40 * i) << 16);
  endfunction

  // Monitor
  logic [160:0] last_out = '0;
  logic [160:0] cur_out;
  assign cur_out = {x_out, y_out, vx_out, vy_out, vx_acc_out, vy_acc_out};

  always @(posedge reset) last_out = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_out = '0;
    end else begin
      if (cyc == watch_cyc) chk("no_resp_after_reset", 32'(resp_valid), 32'd0);
      if (resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got resp_valid 1 required 0 (cyc %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("x",      32'(x_out),  32'(e.x));
          chk("y",      32'(y_out),  32'(e.y));
          chk("vx",     32'(vx_out), 32'(e.vx));
          chk("vy",     32'(vy_out), 32'(e.vy));
          chk("vx_acc", vx_acc_out,  e.vxa);
          chk("vy_acc", vy_acc_out,  e.vya);
        end
        last_out = cur_out;
      end else begin
        checks++;
        if (cur_out !== last_out) begin
          errors++;
          $display("FAIL out_hold: got %h required %h", cur_out, last_out);
        end
      end
    end
  end

  // Stimulus
  task automatic do_req(input logic we, input int boid, input logic [6:0] wen,
                        input logic [27:0] x, input logic [26:0] y, input logic [20:0] vx,
                        input logic [20:0] vy, input logic [31:0] vxa, input logic [31:0] vya);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      req_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("ready_at_issue", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_boid  = IW'(boid);
    w_en      = wen;
    x_in      = x;
    y_in      = y;
    vx_in     = vx;
    vy_in     = vy;
    vx_acc_in = vxa;
    vy_acc_in = vya;
    if (we) begin
      if (boid < NB && wen[0]) begin
        if (wen[1]) m_x[boid]   = x;
        if (wen[2]) m_y[boid]   = y;
        if (wen[3]) m_vx[boid]  = vx;
        if (wen[4]) m_vy[boid]  = vy;
        if (wen[5]) m_vxa[boid] = vxa;
        if (wen[6]) m_vya[boid] = vya;
      end
    end else begin
      if (boid < NB) begin
        e.x = m_x[boid]; e.y = m_y[boid]; e.vx = m_vx[boid]; e.vy = m_vy[boid];
        e.vxa = m_vxa[boid]; e.vya = m_vya[boid];
      end else begin
        e.x = '0; e.y = '0; e.vx = '0; e.vy = '0; e.vxa = '0; e.vya = '0;
      end
      e.cyc = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic rd(input int boid);
    do_req(1'b0, boid, 7'h00, '0, '0, '0, '0, '0, '0);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for req_ready after reset deasserts, then bring the model in line with memory.
  task automatic after_reset();
    int n;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_rise_cycles", 32'(n), 32'(ExpRdy));
`ifdef BOID_MEM_INIT_EN
    for (int i = 0; i < NB; i++) begin
      m_x[i] = init_x(i); m_y[i] = init_y(i); m_vx[i] = 21'h50000; m_vy[i] = 21'h40000;
      m_vxa[i] = '0; m_vya[i] = '0;
    end
`else
    for (int i = 0; i < NB; i++) begin
      do_req(1'b1, i, 7'h7F, init_x(i), init_y(i), 21'h50000, 21'h40000, '0, '0);
    end
    idle();
`endif
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_boid = '0; w_en = '0;
    x_in = '0; y_in = '0; vx_in = '0; vy_in = '0; vx_acc_in = '0; vy_acc_in = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_outputs_zero", 32'(cur_out != '0), 32'd0);
    reset = 1'b0;
    after_reset();

    // Init contents: boid 1 then boid 0
    rd(1);
    rd(0);
    idle();

    // Masked write: only x of boid 0
    do_req(1'b1, 0, 7'b0000011, 28'h0123456, '1, '1, '1, '1, '1);
    rd(0);
    idle();

    // Global enable low: no field of boid 1 changes
    do_req(1'b1, 1, 7'b1111110, '0, '0, '0, '0, '0, '0);
    rd(1);
    idle();

    // Back-to-back reads, then a write right behind them, then read back
    rd(0);
    rd(1);
    do_req(1'b1, 0, 7'h7F, 28'hABCDEF1, 27'h1234567, 21'h1F00F, 21'h0A0A0, 32'hDEADBEEF,
           32'hCAFEF00D);
    rd(0);
    idle();

    // Out-of-range index
    do_req(1'b1, 2, 7'h7F, '1, '1, '1, '1, '1, '1);
    rd(2);
    rd(0);
    rd(1);
    rd(3);
    idle();

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic [6:0] wen;
      wen = 7'($urandom);
      if ($urandom_range(0, 3) != 0) wen[0] = 1'b1;
      do_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), wen, 28'($urandom),
             27'($urandom), 21'($urandom), 21'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    repeat (4) @(negedge clk);

    // Reset in the cycle after a read is accepted
    rd(0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    sb.delete();
    watch_cyc = cyc + 1;
    #2;
    reset = 1'b0;
    after_reset();
    rd(0);
    rd(1);
    idle();

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
